// File: rtl/spike_event_decoder_if.sv
// Output stream of the spike event decoder: one ISI record per detected spike,
// presented show-ahead with a valid/ready handshake.
interface spike_event_decoder_if #(
    parameter int unsigned ISI_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [ISI_W-1:0] out_isi;
    logic             out_first;
    logic             out_sat;

    modport master (
        output out_valid,
        output out_isi,
        output out_first,
        output out_sat,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_isi,
        input  out_first,
        input  out_sat,
        output out_ready
    );
endinterface

// File: rtl/spike_event_decoder.sv
// Spike detector with threshold/re-arm hysteresis, inter-spike interval counter
// and a small show-ahead FIFO of ISI records.
module spike_event_decoder #(
    parameter logic signed [7:0] VTH_HI = 8'sd16,
    parameter logic signed [7:0] VTH_LO = -8'sd8,
    parameter int unsigned       ISI_W  = 16,
    parameter int unsigned       DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_en,
    input  logic signed [7:0]           v_in,
    output logic                        spike,
    output logic [15:0]                 spike_count,
    output logic [7:0]                  drop_count,
    spike_event_decoder_if.master       evt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned RW = ISI_W + 2;

    typedef enum logic [0:0] {StArmed, StFired} state_e;

    state_e           state_q, state_d;
    logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
    logic             first_pend_q, first_pend_d;
    logic             spike_det;
    logic             isi_sat;
    logic [ISI_W-1:0] isi_inc;
    logic [RW-1:0]    rec_new;

    logic [RW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]      ptr_one;
    logic             empty, full, pop, push, drop;
    logic [RW-1:0]    head;

    logic             spike_q;
    logic [15:0]      spike_count_q;
    logic [7:0]       drop_count_q;

    assign isi_sat = &isi_cnt_q;
    assign isi_inc = isi_sat ? isi_cnt_q : isi_cnt_q + {{(ISI_W-1){1'b0}}, 1'b1};
    assign rec_new = {first_pend_q, isi_sat, isi_inc};

    always_comb begin
        state_d      = state_q;
        isi_cnt_d    = isi_cnt_q;
        first_pend_d = first_pend_q;
        spike_det    = 1'b0;
        if (sample_en) begin
            unique case (state_q)
                StArmed: begin
                    if (v_in > VTH_HI) begin
                        spike_det    = 1'b1;
                        state_d      = StFired;
                        isi_cnt_d    = '0;
                        first_pend_d = 1'b0;
                    end else begin
                        isi_cnt_d = isi_inc;
                    end
                end
                StFired: begin
                    isi_cnt_d = isi_inc;
                    if (v_in < VTH_LO) begin
                        state_d = StArmed;
                    end
                end
                default: state_d = StArmed;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StArmed;
            isi_cnt_q    <= '0;
            first_pend_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            isi_cnt_q    <= isi_cnt_d;
            first_pend_q <= first_pend_d;
        end
    end

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign ptr_one = {{AW{1'b0}}, 1'b1};
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = !empty && evt.out_ready;
    assign push    = spike_det && (!full || pop);
    assign drop    = spike_det && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ptr_one;
            if (pop)  rd_ptr_q <= rd_ptr_q + ptr_one;
        end
    end

    // Storage needs no reset: contents are only visible while non-empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= rec_new;
        end
    end

    assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign evt.out_valid = !empty;
    assign evt.out_first = head[RW-1];
    assign evt.out_sat   = head[RW-2];
    assign evt.out_isi   = head[ISI_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_q       <= 1'b0;
            spike_count_q <= '0;
            drop_count_q  <= '0;
        end else begin
            spike_q <= spike_det;
            if (spike_det) begin
                spike_count_q <= spike_count_q + 16'd1;
            end
            if (drop && (drop_count_q != 8'hFF)) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    assign spike       = spike_q;
    assign spike_count = spike_count_q;
    assign drop_count  = drop_count_q;

endmodule

// File: tb/tb_spike_event_decoder.sv
// Bench for spike_event_decoder: a 16-bit and a 4-bit ISI instance share stimulus and
// are checked against a queue-based reference model, a vector table and directed cases.
module tb_spike_event_decoder;

    localparam int DEPTH = 4;
    localparam int VHI   = 16;
    localparam int VLO   = -8;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_en;
    logic              out_ready;
    logic signed [7:0] v_in;

    logic        spike16, spike4;
    logic [15:0] sc16, sc4;
    logic [7:0]  dc16, dc4;

    always #5 clk = ~clk;

    spike_event_decoder_if #(.ISI_W(16)) if16 ();
    spike_event_decoder_if #(.ISI_W(4))  if4 ();

    assign if16.out_ready = out_ready;
    assign if4.out_ready  = out_ready;

    spike_event_decoder #(.ISI_W(16), .DEPTH(DEPTH)) dut16 (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .v_in        (v_in),
        .spike       (spike16),
        .spike_count (sc16),
        .drop_count  (dc16),
        .evt         (if16)
    );

    spike_event_decoder #(.ISI_W(4), .DEPTH(DEPTH)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .v_in        (v_in),
        .spike       (spike4),
        .spike_count (sc4),
        .drop_count  (dc4),
        .evt         (if4)
    );

    // Reference model: records keep the raw sample distance; each width clamps it.
    typedef struct {
        bit first;
        int n;
    } rec_t;

    rec_t        mq[$];
    bit          m_armed;
    bit          m_seen;
    int          m_idx;
    int          m_last;
    bit          m_spike;
    logic [15:0] m_sc;
    int          m_dc;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit en;
        int v;
        bit rdy;
        bit e_spike;
        bit e_valid;
        bit e_first;
        int e_isi;
    } vec_t;

    vec_t tbl[14];

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_armed = 1'b1;
        m_seen  = 1'b0;
        m_idx   = 0;
        m_last  = -1;
        m_spike = 1'b0;
        m_sc    = '0;
        m_dc    = 0;
    endtask

    task automatic model_step();
        bit   pop;
        bit   det;
        int   vv;
        rec_t r;
        vv  = v_in;
        pop = (mq.size() > 0) && out_ready;
        det = sample_en && m_armed && (vv > VHI);
        r.first = 1'b0;
        r.n     = 0;
        if (sample_en) begin
            if (det) begin
                r.first = !m_seen;
                r.n     = m_idx - m_last;
                m_last  = m_idx;
                m_seen  = 1'b1;
                m_armed = 1'b0;
            end else if (!m_armed && (vv < VLO)) begin
                m_armed = 1'b1;
            end
            m_idx++;
        end
        if (pop) void'(mq.pop_front());
        if (det) begin
            if (mq.size() < DEPTH) mq.push_back(r);
            else if (m_dc < 255) m_dc++;
            m_sc = m_sc + 16'd1;
        end
        m_spike = det;
    endtask

    task automatic check_dut(input string tag, input int maxv, input int spk, input int sc,
                             input int dc, input int vld, input int isi, input int fst,
                             input int sat);
        cmp({tag, ".spike"}, spk, int'(m_spike));
        cmp({tag, ".spike_count"}, sc, int'(m_sc));
        cmp({tag, ".drop_count"}, dc, m_dc);
        cmp({tag, ".out_valid"}, vld, int'(mq.size() > 0));
        if (mq.size() > 0) begin
            cmp({tag, ".out_first"}, fst, int'(mq[0].first));
            if (!mq[0].first) begin
                cmp({tag, ".out_isi"}, isi, (mq[0].n > maxv) ? maxv : mq[0].n);
                cmp({tag, ".out_sat"}, sat, int'(mq[0].n > maxv));
            end
        end else begin
            cmp({tag, ".out_isi_empty"}, isi, 0);
            cmp({tag, ".out_first_empty"}, fst, 0);
            cmp({tag, ".out_sat_empty"}, sat, 0);
        end
    endtask

    task automatic check_all();
        check_dut("w16", 65535, spike16, sc16, dc16, if16.out_valid, if16.out_isi,
                  if16.out_first, if16.out_sat);
        check_dut("w4", 15, spike4, sc4, dc4, if4.out_valid, if4.out_isi,
                  if4.out_first, if4.out_sat);
    endtask

    task automatic step(input bit en, input int v, input bit rdy);
        sample_en = en;
        v_in      = 8'(v);
        out_ready = rdy;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sample_en = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1, 17,  1, 1, 1, 1, 0};
        tbl[1]  = '{1, 20,  1, 0, 0, 0, 0};
        tbl[2]  = '{1, -5,  1, 0, 0, 0, 0};
        tbl[3]  = '{1, 30,  1, 0, 0, 0, 0};
        tbl[4]  = '{1, -9,  1, 0, 0, 0, 0};
        tbl[5]  = '{1, 17,  1, 1, 1, 0, 5};
        tbl[6]  = '{1, -23, 1, 0, 0, 0, 0};
        tbl[7]  = '{1, 16,  1, 0, 0, 0, 0};
        tbl[8]  = '{1, 17,  1, 1, 1, 0, 3};
        tbl[9]  = '{0, 17,  0, 0, 1, 0, 3};
        tbl[10] = '{1, -23, 0, 0, 1, 0, 3};
        tbl[11] = '{1, 17,  0, 1, 1, 0, 3};
        tbl[12] = '{1, -40, 1, 0, 1, 0, 2};
        tbl[13] = '{1, -40, 1, 0, 0, 0, 0};

        rst = 1'b1;
        sample_en = 1'b0;
        out_ready = 1'b0;
        v_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Vector table, straight out of reset
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].en, tbl[i].v, tbl[i].rdy);
            cmp($sformatf("tbl[%0d].spike", i), spike16, int'(tbl[i].e_spike));
            cmp($sformatf("tbl[%0d].valid", i), if16.out_valid, int'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                cmp($sformatf("tbl[%0d].first", i), if16.out_first, int'(tbl[i].e_first));
                if (!tbl[i].e_first)
                    cmp($sformatf("tbl[%0d].isi", i), if16.out_isi, tbl[i].e_isi);
            end
        end

        // Asynchronous reset with two records queued
        step(1, -30, 0);
        step(1, 17, 0);
        step(1, -23, 0);
        step(1, 17, 0);
        cmp("pre_rst.valid", if16.out_valid, 1);
        rst = 1'b1;
        #2;
        cmp("async_rst.valid", if16.out_valid, 0);
        cmp("async_rst.spike", spike16, 0);
        cmp("async_rst.spike_count", sc16, 0);
        cmp("async_rst.drop_count", dc16, 0);
        cmp("async_rst.isi", if16.out_isi, 0);
        cmp("async_rst.first", if16.out_first, 0);
        cmp("async_rst.valid4", if4.out_valid, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) step(1, -40, 1);
        cmp("idle.spike_count", sc16, 0);

        // Basic ISI
        step(1, 17, 1);
        cmp("basic.spike0", spike16, 1);
        cmp("basic.first", if16.out_first, 1);
        step(1, -23, 1);
        step(1, -10, 1);
        step(1, -10, 1);
        step(1, -10, 1);
        step(1, 17, 1);
        cmp("basic.spike5", spike16, 1);
        cmp("basic.isi", if16.out_isi, 5);
        cmp("basic.first2", if16.out_first, 0);
        cmp("basic.sat", if16.out_sat, 0);
        cmp("basic.spike_count", sc16, 2);

        // sample_en gating
        step(1, -30, 1);
        step(1, 17, 1);
        step(1, -20, 1);
        for (int i = 0; i < 4; i++) step(0, 40, 1);
        step(1, -20, 1);
        for (int i = 0; i < 3; i++) step(0, 40, 1);
        step(1, -20, 1);
        for (int i = 0; i < 3; i++) step(0, 40, 1);
        step(1, 17, 1);
        cmp("gate.isi", if16.out_isi, 4);

        // Backpressure and overflow
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1, 17, 0);
            step(1, -30, 0);
        end
        cmp("ovf.drop_count", dc16, 2);
        cmp("ovf.spike_count", sc16, 6);
        cmp("ovf.head_first", if16.out_first, 1);
        for (int i = 0; i < 4; i++) begin
            cmp($sformatf("drain[%0d].valid", i), if16.out_valid, 1);
            step(0, 0, 1);
        end
        cmp("drain.valid_after", if16.out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 17, 0);
            step(1, -30, 0);
        end
        cmp("refill.drop_count", dc16, 2);
        step(1, 17, 1);
        cmp("full_pop.drop_count", dc16, 2);
        cmp("full_pop.valid", if16.out_valid, 1);

        // Saturation on the 4-bit instance
        do_reset();
        step(1, 17, 1);
        for (int i = 0; i < 20; i++) step(1, -40, 1);
        step(1, 17, 1);
        cmp("sat.isi4", if4.out_isi, 15);
        cmp("sat.sat4", if4.out_sat, 1);
        cmp("sat.isi16", if16.out_isi, 21);
        step(1, -40, 1);
        step(1, -40, 1);
        step(1, 17, 1);
        cmp("unsat.isi4", if4.out_isi, 3);
        cmp("unsat.sat4", if4.out_sat, 0);

        // Randomized traffic with periodic backpressure bursts
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit en;
            bit rdy;
            int v;
            en  = ($urandom_range(0, 3) != 0);
            v   = int'($urandom_range(0, 255)) - 128;
            rdy = ((i % 200) < 150) ? ($urandom_range(0, 3) != 0) : 1'b0;
            step(en, v, rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spike_event_decoder.md
Name: spike_event_decoder

Overview:
- Reader-side companion to the Izhikevich neuron core: consumes the signed 8-bit membrane-voltage sample stream the neuron drives onto its output pins.
- Detects spikes with threshold/re-arm hysteresis and measures inter-spike interval (ISI) in enabled samples.
- Emits one ISI event record per spike through a small show-ahead FIFO with a valid/ready handshake.
- Sits between the neuron output and any downstream spike logger or serializer.

Parameters:
- VTH_HI, 8'sd16, spike threshold; spike when v_in > VTH_HI (strict signed compare, matching the core's firing test).
- VTH_LO, -8'sd8, re-arm level; detector re-arms when v_in < VTH_LO (strict signed). Requirement: VTH_LO < VTH_HI.
- ISI_W, 16, ISI counter and record width.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- sample_en, input, 1, qualifies v_in as a new sample this cycle.
- v_in, input, 8, signed membrane voltage sample.
- spike, output, 1, one-cycle pulse, registered, one cycle after the detecting sample.
- out_valid, output, 1, FIFO head holds a record.
- out_ready, input, 1, consumer accepts the head this cycle.
- out_isi, output, ISI_W, ISI of head record.
- out_first, output, 1, head record is the first spike since reset; out_isi is not meaningful when set.
- out_sat, output, 1, head ISI saturated at all-ones.
- spike_count, output, 16, total detected spikes, including dropped ones; wraps 0xFFFF->0.
- drop_count, output, 8, records lost to a full FIFO; saturates at 0xFF.

Behaviour:
- Reset (async, rst=1): state=ARMED; isi_cnt=0; first_pend=1; FIFO empty; spike=0, out_valid=0, out_isi=0, out_first=0, out_sat=0, spike_count=0, drop_count=0. Applies mid-operation; queued records are discarded.
- Cycles with sample_en=0: detector, isi_cnt and first_pend hold; FIFO pops still occur.
- FSM ARMED, enabled sample with v_in > VTH_HI: this is a spike sample.
  - Next state FIRED; spike=1 next cycle.
  - Record = {first=first_pend, sat, isi}, with isi = sat_inc(isi_cnt) and sat=1 iff isi_cnt is already all-ones; then isi_cnt<=0, first_pend<=0.
  - spike_count increments.
- FSM ARMED, enabled sample, no spike: isi_cnt <= sat_inc(isi_cnt).
- FSM FIRED, enabled sample: isi_cnt <= sat_inc(isi_cnt). If v_in < VTH_LO, next state ARMED. No spike can be detected while FIRED.
  - Spike and re-arm detection use the same sample value; the reset voltage (~-23) re-arms on the first post-spike sample.
- ISI definition: spikes detected at enabled samples k and k+N give isi=N.
- FIFO is show-ahead: out_* reflect the head whenever out_valid=1; head fields read 0 when empty.
  - Pop when out_valid & out_ready.
  - Push on spike sample if not full, or if full and popping in the same cycle.
  - If full with no pop, the record is dropped and drop_count saturating-increments; spike and spike_count still update.
  - Simultaneous push and pop keeps occupancy unchanged.
  - Push into empty FIFO: out_valid rises the cycle after the spike sample (latency 1), concurrent with the spike pulse.
- Head fields must hold stable while out_valid=1 and out_ready=0.
- Pointers wrap modulo DEPTH; track full/empty with an extra pointer bit or an occupancy count.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Reset/idle: assert rst mid-stream with 2 queued records -> all outputs 0 immediately (async), out_valid=0; after release, v_in=-40 for 100 samples -> no spike, spike_count=0.
- Basic ISI: out_ready=1, v_in pattern {17,-23,-10,-10,-10,17} on consecutive enabled samples -> first record out_first=1; second record out_isi=5, out_first=0, out_sat=0; spike pulses one cycle after samples 0 and 5; spike_count=2.
- Hysteresis: ARMED, v_in sequence 17,20,-5,30,-9,17 -> spikes only at samples 0 and 5 (-5 does not re-arm, -9 does); isi=5. Also v_in=16 -> no spike (strict compare).
- sample_en gating: spike, 3 enabled low samples interleaved with 10 cycles of sample_en=0, then spike -> isi=4; state unchanged across gaps.
- Backpressure/overflow: out_ready=0, DEPTH=4, 6 spikes -> 4 records retained in order, drop_count=2, spike_count=6. Then drain with out_ready=1 -> 4 pops, out_valid falls after the 4th. Spike on a full FIFO in the same cycle as a pop -> accepted, drop_count unchanged.
- Saturation: ISI_W=4 build, 20 enabled samples between spikes -> out_isi=15, out_sat=1. Next ISI of 3 -> out_isi=3, out_sat=0.
